// File: rtl/brunch_resolver_pkg.sv
// Shared types for the execute-stage branch resolver: instruction record,
// PC type, resolver FSM states and the delay-slot fall-through offset.
package brunch_resolver_pkg;

  typedef logic [31:0] pc_t;

  typedef struct packed {
    pc_t         pc;
    logic [31:0] inst;
    logic        is_brunch;
    logic        brunch_taken;
  } inst_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_DS  = 2'd1,
    REDIRECT = 2'd2
  } resolver_state_e;

  localparam int unsigned DS_OFFSET   = 8;
  localparam int unsigned NODS_OFFSET = 4;

endpackage

// File: rtl/brunch_resolver_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/brunch_resolver.sv
// Resolves execute-stage control flow against the fetch prediction, flushes
// wrong-path work (respecting the delay slot) and sends a held redirect to fetch.
module brunch_resolver
  import brunch_resolver_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter bit DS_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  inst_t            ex_inst,
  input  pc_t              ex_pred_target,
  input  logic             ex_actual_taken,
  input  pc_t              ex_actual_target,
  input  logic             ds_fetched,
  output logic             flush,
  output logic             redirect_valid,
  input  logic             redirect_ready,
  output pc_t              redirect_pc,
  output logic [CNT_W-1:0] resolved_cnt,
  output logic [CNT_W-1:0] mispredict_cnt,
  output resolver_state_e  o_dbg_state,
  output logic [31:0]      o_dbg_mp_inst
);

  localparam pc_t FALLTHRU = pc_t'(DS_EN ? DS_OFFSET : NODS_OFFSET);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready.
  // redirect_valid, once high, holds itself and redirect_pc until redirect_ready.

  resolver_state_e r_state;
  logic            r_flush;
  logic            r_redirect_valid;
  pc_t             r_redirect_pc;
  logic [31:0]     r_mp_inst;

  logic w_accept;
  logic w_is_cf;
  logic w_mispredict;
  pc_t  w_correct_pc;

  assign ex_ready = (r_state == IDLE);
  assign w_accept = ex_valid && ex_ready;

  always_comb begin
    w_is_cf      = ex_inst.is_brunch || ex_actual_taken;
    w_mispredict = (ex_actual_taken != ex_inst.brunch_taken) ||
                   (ex_actual_taken && ex_inst.brunch_taken &&
                    (ex_actual_target != ex_pred_target));
    w_correct_pc = ex_actual_taken ? ex_actual_target : (ex_inst.pc + FALLTHRU);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= IDLE;
      r_flush          <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_mp_inst        <= '0;
    end else begin
      r_flush <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept && w_mispredict) begin
            r_flush       <= 1'b1;
            r_redirect_pc <= w_correct_pc;
            r_mp_inst     <= ex_inst.inst;
            // The delay slot is on the correct path, so wait until it is in hand.
            if (DS_EN && !ds_fetched) begin
              r_state <= WAIT_DS;
            end else begin
              r_state          <= REDIRECT;
              r_redirect_valid <= 1'b1;
            end
          end
        end
        WAIT_DS: begin
          if (ds_fetched) begin
            r_state          <= REDIRECT;
            r_redirect_valid <= 1'b1;
          end
        end
        REDIRECT: begin
          if (redirect_ready) begin
            r_state          <= IDLE;
            r_redirect_valid <= 1'b0;
          end
        end
        default: begin
          r_state          <= IDLE;
          r_redirect_valid <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_resolved_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_accept && w_is_cf),
    .o_count (resolved_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_mispredict_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_accept && w_mispredict),
    .o_count (mispredict_cnt)
  );

  assign flush          = r_flush;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign o_dbg_state    = r_state;
  assign o_dbg_mp_inst  = r_mp_inst;

endmodule
